majority_voter_bist: RTL and testbench



---
 rtl/majority_voter_bist.sv | 168 ++++++++++++++++
 tb/tb_majority_voter_bist.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/majority_voter_bist.sv
// ---------------------------------------------------------------------------
// majority_voter_bist
//   Self-test driver/checker for a 3-input majority voter. On start it walks
//   the voter inputs through vectors 000..111 and holds each one for
//   HOLD_CYCLES cycles. It then samples the voter output for one cycle and
//   checks it against the expected majority. At the end of the run it reports
//   pass/fail, a saturating mismatch count and the first failing vector.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous reset, active-low
//   i_start      run request, only looked at while idle
//   i_y_in       voter output under test
//   o_y1_out     voter input y1 (vector bit 2)
//   o_y2_out     voter input y2 (vector bit 1)
//   o_y3_out     voter input y3 (vector bit 0)
//   o_busy       high while vectors are being driven/sampled
//   o_done       one-cycle pulse at the end of a run
//   o_pass       1 when the last run saw no mismatches
//   o_err_count  mismatches in the current/last run (saturating)
//   o_fail_vec   first mismatching vector {y1,y2,y3}, 0 if none
// ---------------------------------------------------------------------------
module majority_voter_bist #(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_y_in,
    output logic             o_y1_out,
    output logic             o_y2_out,
    output logic             o_y3_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic [2:0]       o_fail_vec
);

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [2:0]        r_vec;
    logic [HOLD_W-1:0] r_hold;
    logic [ERR_W-1:0]  r_err;
    logic [2:0]        r_fail_vec;
    logic              r_pass;
    logic              r_done;
    logic              r_busy;
    logic [2:0]        r_y;

    state_t            w_state_nxt;
    logic [2:0]        w_vec_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [2:0]        w_fail_vec_nxt;
    logic              w_pass_nxt;
    logic              w_done_nxt;
    logic              w_busy_nxt;
    logic [2:0]        w_y_nxt;
    logic              w_expected;
    logic              w_mismatch;

    assign w_expected = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
    assign w_mismatch = (i_y_in != w_expected);

    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_hold_nxt     = r_hold;
        w_err_nxt      = r_err;
        w_fail_vec_nxt = r_fail_vec;
        w_pass_nxt     = r_pass;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = ST_DRIVE;
                    w_vec_nxt      = 3'd0;
                    w_hold_nxt     = '0;
                    w_err_nxt      = '0;
                    w_fail_vec_nxt = 3'd0;
                    w_pass_nxt     = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    // The count is cleared at start and saturates without
                    // wrapping, so zero here means this is the first mismatch.
                    if (r_err == '0) begin
                        w_fail_vec_nxt = r_vec;
                    end
                    if (r_err != '1) begin
                        w_err_nxt = r_err + ERR_W'(1);
                    end
                end
                if (r_vec == 3'd7) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == '0);
                end else begin
                    w_state_nxt = ST_DRIVE;
                    w_vec_nxt   = r_vec + 3'd1;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up
        // with the state they describe.
        w_busy_nxt = (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
        w_y_nxt    = w_busy_nxt ? w_vec_nxt : 3'd0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_vec      <= 3'd0;
            r_hold     <= '0;
            r_err      <= '0;
            r_fail_vec <= 3'd0;
            r_pass     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_y        <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_hold     <= w_hold_nxt;
            r_err      <= w_err_nxt;
            r_fail_vec <= w_fail_vec_nxt;
            r_pass     <= w_pass_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_y        <= w_y_nxt;
        end
    end

    assign o_y1_out    = r_y[2];
    assign o_y2_out    = r_y[1];
    assign o_y3_out    = r_y[0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_majority_voter_bist.sv
// ---------------------------------------------------------------------------
// tb_majority_voter_bist
//   Two BIST instances (HOLD_CYCLES=4 and HOLD_CYCLES=1) share clock, reset
//   and start. Each drives its own behavioural voter, which can be correct,
//   stuck-at-0, inverting, or corrupted on a random set of vectors. A
//   timeline model predicts every output from the offset into the run and
//   is compared on each falling edge. Literal end-of-run results pin the model.
// ---------------------------------------------------------------------------
module tb_majority_voter_bist;
    localparam int HA = 4;
    localparam int HB = 1;
    localparam int EW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    int         mode;
    logic [7:0] mask;

    logic          ya, a_y1, a_y2, a_y3, a_busy, a_done, a_pass;
    logic [EW-1:0] a_err;
    logic [2:0]    a_fv;
    logic          yb, b_y1, b_y2, b_y3, b_busy, b_done, b_pass;
    logic [EW-1:0] b_err;
    logic [2:0]    b_fv;

    function automatic logic maj(input logic [2:0] v);
        return ($countones(v) >= 2);
    endfunction

    // mode 0: correct, 1: stuck-at-0, 2: inverting, 3: flipped where mask bit set
    function automatic logic voter(input int md, input logic [7:0] mk, input logic [2:0] v);
        case (md)
            0:       return maj(v);
            1:       return 1'b0;
            2:       return ~maj(v);
            default: return maj(v) ^ mk[v];
        endcase
    endfunction

    assign ya = voter(mode, mask, {a_y1, a_y2, a_y3});
    assign yb = voter(mode, mask, {b_y1, b_y2, b_y3});

    majority_voter_bist #(.HOLD_CYCLES(HA), .ERR_W(EW)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_y_in(ya),
        .o_y1_out(a_y1), .o_y2_out(a_y2), .o_y3_out(a_y3),
        .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
        .o_err_count(a_err), .o_fail_vec(a_fv)
    );

    majority_voter_bist #(.HOLD_CYCLES(HB), .ERR_W(EW)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_y_in(yb),
        .o_y1_out(b_y1), .o_y2_out(b_y2), .o_y3_out(b_y3),
        .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
        .o_err_count(b_err), .o_fail_vec(b_fv)
    );

    // Model: phase 0 idle, 1 running (t = cycles since accept), 2 done cycle.
    typedef struct {
        int phase;
        int t;
        int err;
        int fv;
        bit pass;
    } mstate_t;

    function automatic mstate_t mstep(input mstate_t s, input int h, input logic rn,
                                      input logic st, input logic y);
        mstate_t n;
        int per;
        int v;
        n   = s;
        per = h + 1;
        if (rn !== 1'b1) begin
            n.phase = 0; n.t = 0; n.err = 0; n.fv = 0; n.pass = 0;
            return n;
        end
        case (s.phase)
            0: begin
                if (st === 1'b1) begin
                    n.phase = 1; n.t = 0; n.err = 0; n.fv = 0; n.pass = 0;
                end
            end
            1: begin
                v = s.t / per;
                if (s.t % per == h) begin
                    if (y !== maj(v[2:0])) begin
                        if (s.err == 0) n.fv = v;
                        if (s.err < (1 << EW) - 1) n.err = s.err + 1;
                    end
                    if (v == 7) begin
                        n.phase = 2;
                        n.pass  = (n.err == 0);
                    end else begin
                        n.t = s.t + 1;
                    end
                end else begin
                    n.t = s.t + 1;
                end
            end
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] mvec(input mstate_t s, input int h);
        int v;
        v = s.t / (h + 1);
        return (s.phase == 1) ? v[2:0] : 3'd0;
    endfunction

    mstate_t ma;
    mstate_t mb;
    initial begin
        ma = '{0, 0, 0, 0, 1'b0};
        mb = '{0, 0, 0, 0, 1'b0};
    end

    always @(posedge clk) begin
        ma <= mstep(ma, HA, rst_n, start, ya);
        mb <= mstep(mb, HB, rst_n, start, yb);
    end

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A_vec",  32'({a_y1, a_y2, a_y3}), 32'(mvec(ma, HA)));
            chk("A_busy", 32'(a_busy), 32'(ma.phase == 1));
            chk("A_done", 32'(a_done), 32'(ma.phase == 2));
            chk("A_pass", 32'(a_pass), 32'(ma.pass));
            chk("A_err",  32'(a_err),  32'(ma.err));
            chk("A_fvec", 32'(a_fv),   32'(ma.fv));
            chk("B_vec",  32'({b_y1, b_y2, b_y3}), 32'(mvec(mb, HB)));
            chk("B_busy", 32'(b_busy), 32'(mb.phase == 1));
            chk("B_done", 32'(b_done), 32'(mb.phase == 2));
            chk("B_pass", 32'(b_pass), 32'(mb.pass));
            chk("B_err",  32'(b_err),  32'(mb.err));
            chk("B_fvec", 32'(b_fv),   32'(mb.fv));
        end
    end

    // Pulse start for one edge, then count cycles from the accepting edge to
    // each instance's done pulse. -1 means the bound expired.
    task automatic run_wait(output int la, output int lb);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        la = -1;
        lb = -1;
        for (int k = 0; k < 200 && la < 0; k++) begin
            if (b_done && lb < 0) lb = k;
            if (a_done) la = k;
            if (la < 0) @(negedge clk);
        end
    endtask

    initial begin
        int la, lb, nd, d0, d1, exp_fv;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        mask  = 8'h00;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_vec",  32'({a_y1, a_y2, a_y3}), 0);
        chk("rst_err",  32'(a_err), 0);
        chk("rst_pass", 32'(a_pass), 0);
        rst_n = 1'b1;

        // Correct voter: both hold lengths pass
        mode = 0;
        run_wait(la, lb);
        chk("t1_latA", la, 40);
        chk("t1_latB", lb, 16);
        chk("t1_pass", 32'(a_pass), 1);
        chk("t1_err",  32'(a_err), 0);
        chk("t1_fvec", 32'(a_fv), 0);
        chk("t6_passB", 32'(b_pass), 1);

        // Stuck-at-0 voter
        mode = 1;
        run_wait(la, lb);
        chk("t2_err",  32'(a_err), 4);
        chk("t2_fvec", 32'(a_fv), 3);
        chk("t2_pass", 32'(a_pass), 0);

        // Inverting voter
        mode = 2;
        run_wait(la, lb);
        chk("t3_err",  32'(a_err), 8);
        chk("t3_fvec", 32'(a_fv), 0);
        chk("t3_pass", 32'(a_pass), 0);

        // Start held high: back-to-back runs separated by DONE + one IDLE cycle
        mode = 0;
        nd = 0; d0 = 0; d1 = 0;
        @(negedge clk) start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (a_done) begin
                nd++;
                if (nd == 1) d0 = i;
                else if (nd == 2) d1 = i;
            end
        end
        start = 1'b0;
        chk("t4_ndone", nd, 2);
        chk("t4_first", d0, 41);
        chk("t4_gap",   d1 - d0, 42);
        repeat (60) @(negedge clk);

        // Reset mid-run while vector 3 is being driven
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_vec3", 32'({a_y1, a_y2, a_y3}), 3);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("t5_busy", 32'(a_busy), 0);
        chk("t5_vec",  32'({a_y1, a_y2, a_y3}), 0);
        chk("t5_err",  32'(a_err), 0);
        chk("t5_done", 32'(a_done), 0);
        run_wait(la, lb);
        chk("t5_lat",  la, 40);
        chk("t5_pass", 32'(a_pass), 1);
        chk("t5_errr", 32'(a_err), 0);

        // Random fault masks
        mode = 3;
        for (int r = 0; r < 8; r++) begin
            mask = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_wait(la, lb);
            exp_fv = 0;
            for (int v = 7; v >= 0; v--) if (mask[v]) exp_fv = v;
            chk("rnd_lat",  la, 40);
            chk("rnd_err",  32'(a_err), 32'($countones(mask)));
            chk("rnd_fvec", 32'(a_fv), 32'(exp_fv));
            chk("rnd_pass", 32'(a_pass), 32'(mask == 8'h00));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
